// File: rtl/axi4_lite_bresp_monitor.sv
// ----------------------------------------------------------------------------
// axi4_lite_bresp_monitor
// Passive AXI4-Lite write-response checker. Taps the AW, W and B handshakes,
// tracks outstanding writes and raises sticky protocol-error flags plus
// saturating OKAY / non-OKAY response statistics.
//
// Ports:
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   AWVALID/AWREADY      write-address handshake tap
//   WVALID/WREADY        write-data handshake tap
//   BVALID/BREADY/BRESP  write-response handshake tap
//   clr_err              synchronous clear of error flags (set wins)
//   err_flags[4:0]       sticky: 0 BVALID_DROP, 1 BRESP_CHANGE,
//                        2 B_UNEXPECTED, 3 OVERFLOW, 4 TIMEOUT
//   irq                  registered OR of err_flags
//   aw_pending/w_pending outstanding AW / W handshakes
//   resp_ok_cnt/resp_err_cnt  saturating B handshake counters
// ----------------------------------------------------------------------------
module axi4_lite_bresp_monitor #(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 16,
   parameter int unsigned CNT_WIDTH       = 16,
   localparam int unsigned PW             = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                 ACLK,
   input  logic                 ARESETN,
   input  logic                 AWVALID,
   input  logic                 AWREADY,
   input  logic                 WVALID,
   input  logic                 WREADY,
   input  logic                 BVALID,
   input  logic                 BREADY,
   input  logic [1:0]           BRESP,
   input  logic                 clr_err,
   output logic [4:0]           err_flags,
   output logic                 irq,
   output logic [PW-1:0]        aw_pending,
   output logic [PW-1:0]        w_pending,
   output logic [CNT_WIDTH-1:0] resp_ok_cnt,
   output logic [CNT_WIDTH-1:0] resp_err_cnt
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [PW-1:0] PEND_MAX = PW'(MAX_OUTSTANDING);
   localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic aw_hs_c, w_hs_c, b_hs_c;

   logic [PW-1:0]        aw_pend_q, aw_pend_d;
   logic [PW-1:0]        w_pend_q,  w_pend_d;
   logic [TW-1:0]        tmr_q,     tmr_d;
   logic                 bvalid_q,  bready_q;
   logic [1:0]           bresp_q;
   logic [4:0]           flags_q,   flags_d;
   logic [4:0]           set_c;
   logic                 irq_q,     irq_d;
   logic [CNT_WIDTH-1:0] ok_q,      ok_d;
   logic [CNT_WIDTH-1:0] err_q,     err_d;
   logic                 both_pend_c;

   assign aw_hs_c     = AWVALID & AWREADY;
   assign w_hs_c      = WVALID  & WREADY;
   assign b_hs_c      = BVALID  & BREADY;
   assign both_pend_c = (aw_pend_q != '0) && (w_pend_q != '0);

   // Next-state logic for counts, timer, flags and statistics
   always_comb begin
      aw_pend_d = aw_pend_q;
      w_pend_d  = w_pend_q;
      tmr_d     = tmr_q;
      set_c     = '0;
      ok_d      = ok_q;
      err_d     = err_q;

      // Outstanding AW count: saturates at max, floors at zero
      if (aw_hs_c && !b_hs_c) begin
         if (aw_pend_q != PEND_MAX) aw_pend_d = aw_pend_q + PW'(1);
         else                       set_c[3]  = 1'b1;
      end else if (!aw_hs_c && b_hs_c && (aw_pend_q != '0)) begin
         aw_pend_d = aw_pend_q - PW'(1);
      end

      // Outstanding W count: same rules
      if (w_hs_c && !b_hs_c) begin
         if (w_pend_q != PEND_MAX) w_pend_d = w_pend_q + PW'(1);
         else                      set_c[3] = 1'b1;
      end else if (!w_hs_c && b_hs_c && (w_pend_q != '0)) begin
         w_pend_d = w_pend_q - PW'(1);
      end

      // B stability checks against the previous cycle's B channel
      set_c[0] = bvalid_q & ~bready_q & ~BVALID;
      set_c[1] = bvalid_q & ~bready_q & BVALID & (BRESP != bresp_q);
      set_c[2] = BVALID & ((aw_pend_q == '0) || (w_pend_q == '0));

      // Response timer holds at its limit so TIMEOUT fires once per stall
      if (b_hs_c || !both_pend_c) begin
         tmr_d = '0;
      end else if (tmr_q != TMR_MAX) begin
         tmr_d = tmr_q + TW'(1);
         if (tmr_q == TMR_LAST) set_c[4] = 1'b1;
      end

      // Saturating response statistics
      if (b_hs_c) begin
         if (BRESP == 2'b00) begin
            if (ok_q != '1) ok_d = ok_q + CNT_WIDTH'(1);
         end else begin
            if (err_q != '1) err_d = err_q + CNT_WIDTH'(1);
         end
      end

      // Sticky flags; a concurrent set overrides clr_err
      flags_d = (clr_err ? 5'b0 : flags_q) | set_c;
      irq_d   = |flags_q;
   end

   // State registers
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_pend_q <= '0;
         w_pend_q  <= '0;
         tmr_q     <= '0;
         bvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         bresp_q   <= 2'b00;
         flags_q   <= '0;
         irq_q     <= 1'b0;
         ok_q      <= '0;
         err_q     <= '0;
      end else begin
         aw_pend_q <= aw_pend_d;
         w_pend_q  <= w_pend_d;
         tmr_q     <= tmr_d;
         bvalid_q  <= BVALID;
         bready_q  <= BREADY;
         bresp_q   <= BRESP;
         flags_q   <= flags_d;
         irq_q     <= irq_d;
         ok_q      <= ok_d;
         err_q     <= err_d;
      end
   end

   assign err_flags    = flags_q;
   assign irq          = irq_q;
   assign aw_pending   = aw_pend_q;
   assign w_pending    = w_pend_q;
   assign resp_ok_cnt  = ok_q;
   assign resp_err_cnt = err_q;

endmodule

// File: tb/tb_axi4_lite_bresp_monitor.sv
// ----------------------------------------------------------------------------
// tb_axi4_lite_bresp_monitor
// Directed vectors with hand-computed expectations for the B-channel monitor
// using default parameters (MAX_OUTSTANDING=4, TIMEOUT_CYCLES=16).
// ----------------------------------------------------------------------------
module tb_axi4_lite_bresp_monitor;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic [1:0]  BRESP;
   logic        clr_err;
   logic [4:0]  err_flags;
   logic        irq;
   logic [2:0]  aw_pending, w_pending;
   logic [15:0] resp_ok_cnt, resp_err_cnt;

   int errors = 0;
   int checks = 0;

   axi4_lite_bresp_monitor dut (
      .ACLK         (ACLK),
      .ARESETN      (ARESETN),
      .AWVALID      (AWVALID),
      .AWREADY      (AWREADY),
      .WVALID       (WVALID),
      .WREADY       (WREADY),
      .BVALID       (BVALID),
      .BREADY       (BREADY),
      .BRESP        (BRESP),
      .clr_err      (clr_err),
      .err_flags    (err_flags),
      .irq          (irq),
      .aw_pending   (aw_pending),
      .w_pending    (w_pending),
      .resp_ok_cnt  (resp_ok_cnt),
      .resp_err_cnt (resp_err_cnt)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge ACLK);
         #1;
      end
   endtask

   task automatic idle_in();
      AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0;
      BVALID = 0; BREADY = 0; BRESP = 2'b00; clr_err = 0;
   endtask

   task automatic do_reset();
      idle_in();
      ARESETN = 0;
      tick(2);
      ARESETN = 1;
   endtask

   task automatic write_hs();
      AWVALID = 1; AWREADY = 1; WVALID = 1; WREADY = 1;
      tick();
      AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0;
   endtask

   task automatic resp_hs(input logic [1:0] r);
      BVALID = 1; BREADY = 1; BRESP = r;
      tick();
      BVALID = 0; BREADY = 0; BRESP = 2'b00;
   endtask

   initial begin
      idle_in();
      ARESETN = 0;
      #12;
      chk("rst_flags", 32'(err_flags), 32'h0);
      chk("rst_irq",   32'(irq), 32'h0);
      chk("rst_awp",   32'(aw_pending), 32'h0);
      chk("rst_ok",    32'(resp_ok_cnt), 32'h0);
      do_reset();

      // Single write
      write_hs();
      chk("sw_awp1", 32'(aw_pending), 32'h1);
      chk("sw_wp1",  32'(w_pending),  32'h1);
      tick();
      resp_hs(2'b00);
      chk("sw_awp0", 32'(aw_pending), 32'h0);
      chk("sw_wp0",  32'(w_pending),  32'h0);
      chk("sw_ok",   32'(resp_ok_cnt), 32'h1);
      tick();
      chk("sw_flags", 32'(err_flags), 32'h0);

      // BVALID dropped while unaccepted
      write_hs();
      BVALID = 1; BREADY = 0;
      tick(2);
      BVALID = 0;
      tick();
      chk("drop_flag", 32'(err_flags), 32'h01);
      chk("drop_irq0", 32'(irq), 32'h0);
      tick();
      chk("drop_irq1", 32'(irq), 32'h1);
      clr_err = 1;
      tick();
      clr_err = 0;
      chk("clr_flags", 32'(err_flags), 32'h0);
      tick();
      chk("clr_irq", 32'(irq), 32'h0);
      resp_hs(2'b00);
      chk("drop_ok", 32'(resp_ok_cnt), 32'h2);

      // BRESP changes while BVALID held
      write_hs();
      BVALID = 1; BREADY = 0; BRESP = 2'b00;
      tick();
      BRESP = 2'b10;
      tick();
      chk("chg_flag", 32'(err_flags), 32'h02);
      resp_hs(2'b10);
      chk("chg_errcnt", 32'(resp_err_cnt), 32'h1);
      chk("chg_flag2",  32'(err_flags), 32'h02);

      // clr_err with a concurrent set: set wins
      clr_err = 1; BVALID = 1; BREADY = 0;
      tick();
      clr_err = 0; BVALID = 0;
      chk("setwins", 32'(err_flags), 32'h04);

      // Unexpected B after reset
      do_reset();
      chk("unx_pre", 32'(err_flags), 32'h0);
      BVALID = 1; BREADY = 0;
      tick();
      chk("unx_flag", 32'(err_flags), 32'h04);

      // Overflow, then AW + B in the same cycle
      do_reset();
      AWVALID = 1; AWREADY = 1; WVALID = 1; WREADY = 1;
      tick(4);
      chk("ovf_pre", 32'(err_flags), 32'h0);
      tick();
      AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0;
      chk("ovf_awp",  32'(aw_pending), 32'h4);
      chk("ovf_wp",   32'(w_pending),  32'h4);
      chk("ovf_flag", 32'(err_flags), 32'h08);
      AWVALID = 1; AWREADY = 1;
      resp_hs(2'b00);
      AWVALID = 0; AWREADY = 0;
      chk("ovf_awp2", 32'(aw_pending), 32'h4);
      chk("ovf_wp2",  32'(w_pending),  32'h3);
      chk("ovf_ok",   32'(resp_ok_cnt), 32'h1);
      chk("ovf_flag2", 32'(err_flags), 32'h08);

      // Timeout after 16 stalled edges
      do_reset();
      write_hs();
      tick(15);
      chk("to_pre",  32'(err_flags), 32'h0);
      tick();
      chk("to_flag", 32'(err_flags), 32'h10);
      resp_hs(2'b10);
      chk("to_err",  32'(resp_err_cnt), 32'h1);
      chk("to_awp",  32'(aw_pending), 32'h0);

      // Timer restarted from zero: new stall needs a full 16 edges again
      clr_err = 1;
      write_hs();
      clr_err = 0;
      tick(15);
      chk("to_restart", 32'(err_flags), 32'h0);

      // Asynchronous reset mid-stall
      tick(2);
      ARESETN = 0;
      #1;
      chk("arst_flags", 32'(err_flags), 32'h0);
      chk("arst_awp",   32'(aw_pending), 32'h0);
      chk("arst_wp",    32'(w_pending),  32'h0);
      chk("arst_err",   32'(resp_err_cnt), 32'h0);
      chk("arst_irq",   32'(irq), 32'h0);
      ARESETN = 1;
      tick();
      chk("arst_post",  32'(err_flags), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
